pico_wb8_bridge: RTL and testbench
==================================

Name: pico_wb8_bridge

Overview:
Bridges the picorv32 native memory interface to an 8-bit Wishbone classic master port feeding the byte-wide peripherals, such as the GPIO block.
- Each 32-bit CPU access is split into sequential byte beats.
- Writes run only the byte lanes enabled by mem_wstrb.
- Reads fetch all four lanes and assemble them little-endian.
- The block sits between the CPU core and the top-level peripheral address decoder.

Parameters:
ADDR_W, 8, width of wb_adr_o (byte address). Low 2 bits are the lane; upper bits are mem_addr[ADDR_W-1:2].
ERR_DATA, 32'hFFFF_FFFF, value returned on mem_rdata when a read ends in error.
TIMEOUT_CYCLES, 255, per-beat wait limit. Used only with WB_BRIDGE_TIMEOUT_EN.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
mem_valid  in  1  CPU request valid
mem_addr  in  32  CPU byte address (bits 1:0 ignored)
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  byte write enables; 0 means read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
wb_adr_o  out  ADDR_W  Wishbone byte address
wb_dat_o  out  8  write byte
wb_dat_i  in  8  read byte
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  constant 3'b000 (classic)
wb_bte_o  out  2  constant 2'b00
wb_ack_i  in  1  beat acknowledge
wb_err_i  in  1  beat error
o_bus_err  out  1  one-cycle pulse with mem_ready when the transaction errored

Behaviour:
- Reset: i_reset_n is synchronous and active-low; clock is i_clk. Reset clears state to IDLE and drives mem_ready, mem_rdata, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o and o_bus_err to 0.
- States: IDLE, BUS, GAP, DONE. All outputs are registered.
- IDLE:
  - Transition occurs when mem_valid=1.
  - Latch addr, wdata and wstrb.
  - Lane mask = wstrb if wstrb≠0, else 4'hF. we = |wstrb.
  - Select the lowest set mask bit as the lane, then go to BUS.
- BUS:
  - Drives cyc=stb=1.
  - wb_adr_o = {addr[ADDR_W-1:2], lane}.
  - wb_dat_o = wdata[8*lane+:8].
  - wb_we_o = we.
- BUS, on wb_ack_i:
  - For reads, capture wb_dat_i into rdata[8*lane+:8].
  - Clear the mask bit.
  - If mask is still nonzero, go to GAP; otherwise go to DONE.
- BUS, on wb_err_i: err wins over a simultaneous ack. Set the err flag, abort the remaining lanes and go to DONE.
- GAP:
  - One cycle with cyc=1, stb=0.
  - Select the next lowest lane, then go to BUS.
  - Stb therefore never stays high across two beats.
- DONE:
  - mem_ready=1 for exactly one cycle.
  - mem_rdata = assembled data for reads, ERR_DATA for an errored read, 0 for writes.
  - o_bus_err = err flag. cyc=stb=0.
  - Next state is IDLE.
  - mem_valid is not re-sampled until IDLE, so a request held across DONE is not duplicated.
- Latency with a zero-wait slave (ack in the first BUS cycle):
  - N-lane write: mem_ready at cycle 2N after IDLE samples mem_valid.
  - Full read: mem_ready at cycle 8.
- Wait states: the BUS state holds until ack or err; there is no limit unless WB_BRIDGE_TIMEOUT_EN is defined.
- wb_ack_i and wb_err_i outside BUS are ignored.
- Reset mid-transaction: next cycle cyc=stb=0 and state is IDLE. Completed beats of a partial write are not replayed, and no mem_ready is issued.
- mem_rdata holds its value after DONE; it is only meaningful while mem_ready=1.

Optional Feature:
WB_BRIDGE_TIMEOUT_EN.
- When defined, a per-beat counter (8 bits minimum, wide enough for TIMEOUT_CYCLES) clears on entry to BUS and increments each BUS cycle without ack or err.
- When the counter reaches TIMEOUT_CYCLES, the beat is treated exactly as wb_err_i: abort, DONE, o_bus_err=1, and ERR_DATA on reads.
- When undefined, no counter exists and BUS waits indefinitely.

Test Plan:
1. Write with addr=0x04, wdata=0x000000A5, wstrb=0001, ack in the same cycle as stb -> one beat (adr=0x04, dat=0xA5, we=1); mem_ready at cycle 2; o_bus_err=0.
2. Write with wstrb=1010, wdata=0x11223344 -> two beats: adr lane1 dat 0x33, GAP cycle with stb=0, adr lane3 dat 0x11; mem_ready at cycle 4.
3. Read at addr=0, slave returns 0x01, 0x02, 0x03, 0x04 for lanes 0-3 -> mem_rdata=0x04030201 with mem_ready at cycle 8; stb low in cycles 2, 4, 6.
4. Read with wb_err_i on lane 1 -> lanes 2-3 not issued; mem_rdata=0xFFFFFFFF; o_bus_err=1 in the same cycle as mem_ready.
5. Reset asserted during the GAP of a 4-lane write -> next cycle cyc=stb=0; no mem_ready; a new request then starts cleanly at lane 0.
6. With WB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks -> abort after 4 BUS cycles; mem_ready=1 and o_bus_err=1.

Source files
------------

// File: rtl/pico_wb8_bridge_if.sv
// Bundles the CPU-side native memory signals and the 8-bit Wishbone port of the bridge.
// No logic; the "master" modport is the bridge's view (CPU slave, Wishbone master).
// The "slave" modport is the view of the CPU core plus the peripheral decoder.
interface pico_wb8_bridge_if #(
   parameter int ADDR_W = 8
);
   logic              mem_valid;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_ready;
   logic [31:0]       mem_rdata;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [7:0]        wb_dat_o;
   logic [7:0]        wb_dat_i;
   logic              wb_we_o;
   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic [2:0]        wb_cti_o;
   logic [1:0]        wb_bte_o;
   logic              wb_ack_i;
   logic              wb_err_i;
   logic              o_bus_err;

   modport master (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata,
      output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
      input  wb_dat_i, wb_ack_i, wb_err_i,
      output o_bus_err
   );

   modport slave (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata,
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
      output wb_dat_i, wb_ack_i, wb_err_i,
      input  o_bus_err
   );
endinterface

// File: rtl/pico_wb8_bridge.sv
// Splits picorv32 32-bit accesses into 8-bit Wishbone classic beats (reads: all lanes, writes: strobed lanes).
// Latency with zero-wait slave: 2 cycles per beat; mem_ready at cycle 2N (8 for a full read).
// Backpressure: BUS holds until wb_ack_i/wb_err_i; optional per-beat timeout via WB_BRIDGE_TIMEOUT_EN.
module pico_wb8_bridge #(
   parameter int          ADDR_W         = 8,
   parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input logic               i_clk,
   input logic               i_reset_n,
   pico_wb8_bridge_if.master bus
);

   typedef enum logic [1:0] {IDLE, BUS, GAP, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-3:0] addr_q, addr_nxt;
   logic [31:0]       wdata_q, wdata_nxt;
   logic [3:0]        mask_q, mask_nxt;
   logic              we_q, we_nxt;
   logic [1:0]        lane_q, lane_nxt;
   logic [31:0]       rdata_q, rdata_nxt;
   logic              err_q, err_nxt;

   logic              ready_q, ready_nxt;
   logic [31:0]       mem_rdata_q, mem_rdata_nxt;
   logic [ADDR_W-1:0] adr_q, adr_nxt;
   logic [7:0]        dat_q, dat_nxt;
   logic              wbwe_q, wbwe_nxt;
   logic              cyc_q, cyc_nxt;
   logic              stb_q, stb_nxt;
   logic              bus_err_q, bus_err_nxt;

   logic              timeout_hit;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   function automatic logic [1:0] low_lane(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

`ifdef WB_BRIDGE_TIMEOUT_EN
   localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TO_W-1:0] to_cnt_q;

   // Count stalled BUS cycles; restarts at zero every time BUS is entered
   always_ff @(posedge i_clk) begin
      if (!i_reset_n)        to_cnt_q <= '0;
      else if (state == BUS) to_cnt_q <= to_cnt_q + 1'b1;
      else                   to_cnt_q <= '0;
   end

   assign timeout_hit = (state == BUS) && !bus.wb_ack_i && !bus.wb_err_i &&
                        ((to_cnt_q + 1'b1) == TO_W'(TIMEOUT_CYCLES));
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, datapath and registered-output values for the following cycle
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      mask_nxt  = mask_q;
      we_nxt    = we_q;
      lane_nxt  = lane_q;
      rdata_nxt = rdata_q;
      err_nxt   = err_q;

      case (state)
         IDLE: begin
            if (bus.mem_valid) begin
               addr_nxt  = bus.mem_addr[ADDR_W-1:2];
               wdata_nxt = bus.mem_wdata;
               mask_nxt  = (bus.mem_wstrb != 4'h0) ? bus.mem_wstrb : 4'hF;
               we_nxt    = |bus.mem_wstrb;
               lane_nxt  = low_lane(mask_nxt);
               rdata_nxt = '0;
               err_nxt   = 1'b0;
               state_nxt = BUS;
            end
         end
         BUS: begin
            // Error (or timeout) takes priority over a coincident ack
            if (bus.wb_err_i || timeout_hit) begin
               err_nxt   = 1'b1;
               mask_nxt  = 4'h0;
               state_nxt = DONE;
            end else if (bus.wb_ack_i) begin
               if (!we_q) rdata_nxt[{lane_q, 3'b000} +: 8] = bus.wb_dat_i;
               mask_nxt  = mask_q & ~(4'b0001 << lane_q);
               state_nxt = (mask_nxt != 4'h0) ? GAP : DONE;
            end
         end
         GAP: begin
            lane_nxt  = low_lane(mask_q);
            state_nxt = BUS;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Outputs are derived from the next state so they are registered
      cyc_nxt  = (state_nxt == BUS) || (state_nxt == GAP);
      stb_nxt  = (state_nxt == BUS);
      wbwe_nxt = cyc_nxt && we_nxt;
      adr_nxt  = adr_q;
      dat_nxt  = dat_q;
      if (state_nxt == BUS) begin
         adr_nxt = {addr_nxt, lane_nxt};
         dat_nxt = wdata_nxt[{lane_nxt, 3'b000} +: 8];
      end
      ready_nxt     = (state_nxt == DONE);
      bus_err_nxt   = (state_nxt == DONE) && err_nxt;
      mem_rdata_nxt = mem_rdata_q;
      if (state_nxt == DONE)
         mem_rdata_nxt = we_nxt ? 32'h0 : (err_nxt ? ERR_DATA : rdata_nxt);
   end

   // State, transaction context and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         we_q        <= 1'b0;
         lane_q      <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
         mem_rdata_q <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         wbwe_q      <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         addr_q      <= addr_nxt;
         wdata_q     <= wdata_nxt;
         mask_q      <= mask_nxt;
         we_q        <= we_nxt;
         lane_q      <= lane_nxt;
         rdata_q     <= rdata_nxt;
         err_q       <= err_nxt;
         ready_q     <= ready_nxt;
         mem_rdata_q <= mem_rdata_nxt;
         adr_q       <= adr_nxt;
         dat_q       <= dat_nxt;
         wbwe_q      <= wbwe_nxt;
         cyc_q       <= cyc_nxt;
         stb_q       <= stb_nxt;
         bus_err_q   <= bus_err_nxt;
      end
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.wb_adr_o  = adr_q;
   assign bus.wb_dat_o  = dat_q;
   assign bus.wb_we_o   = wbwe_q;
   assign bus.wb_cyc_o  = cyc_q;
   assign bus.wb_stb_o  = stb_q;
   assign bus.wb_cti_o  = 3'b000;
   assign bus.wb_bte_o  = 2'b00;
   assign bus.o_bus_err = bus_err_q;

endmodule

// File: tb/tb_pico_wb8_bridge.sv
// Directed bench for pico_wb8_bridge: single/sparse writes, full read, error abort, wait states, reset abort.
// Inputs change and outputs are sampled on the falling clock edge.
// Define WB_BRIDGE_TIMEOUT_EN to build with TIMEOUT_CYCLES=4 and exercise the timeout abort.
module tb_pico_wb8_bridge;

`ifdef WB_BRIDGE_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pico_wb8_bridge_if #(.ADDR_W(8)) bus ();

   pico_wb8_bridge #(
      .ADDR_W        (8),
      .ERR_DATA      (32'hFFFF_FFFF),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .bus      (bus)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = a;
      bus.mem_wdata = d;
      bus.mem_wstrb = s;
   endtask

   initial begin
      logic [31:0] wd;
      bit          ok;

      rst_n          = 1'b0;
      bus.mem_valid  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.mem_wstrb  = '0;
      bus.wb_dat_i   = '0;
      bus.wb_ack_i   = 1'b0;
      bus.wb_err_i   = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_ready", bus.mem_ready, 0);
      chk("rst_rdata", bus.mem_rdata, 0);
      chk("rst_adr",   bus.wb_adr_o, 0);
      chk("rst_dat",   bus.wb_dat_o, 0);
      chk("rst_we",    bus.wb_we_o, 0);
      chk("rst_cyc",   bus.wb_cyc_o, 0);
      chk("rst_stb",   bus.wb_stb_o, 0);
      chk("rst_err",   bus.o_bus_err, 0);
      chk("cti",       bus.wb_cti_o, 0);
      chk("bte",       bus.wb_bte_o, 0);
      rst_n = 1'b1;
      tick();

      // 1: single-lane write, zero-wait slave
      req(32'h04, 32'h0000_00A5, 4'b0001);
      tick();
      chk("w1_cyc", bus.wb_cyc_o, 1);
      chk("w1_stb", bus.wb_stb_o, 1);
      chk("w1_adr", bus.wb_adr_o, 8'h04);
      chk("w1_dat", bus.wb_dat_o, 8'hA5);
      chk("w1_we",  bus.wb_we_o, 1);
      chk("w1_rdy_early", bus.mem_ready, 0);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;
      chk("w1_ready", bus.mem_ready, 1);
      chk("w1_err",   bus.o_bus_err, 0);
      chk("w1_rdata", bus.mem_rdata, 0);
      chk("w1_cyc_done", bus.wb_cyc_o, 0);
      bus.mem_valid = 1'b0;
      tick();
      chk("w1_ready_pulse", bus.mem_ready, 0);

      // 2: sparse write, lanes 1 and 3 with a GAP between
      req(32'h08, 32'h1122_3344, 4'b1010);
      tick();
      chk("w2_stb_a", bus.wb_stb_o, 1);
      chk("w2_adr_a", bus.wb_adr_o, 8'h09);
      chk("w2_dat_a", bus.wb_dat_o, 8'h33);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;
      chk("w2_gap_stb", bus.wb_stb_o, 0);
      chk("w2_gap_cyc", bus.wb_cyc_o, 1);
      tick();
      chk("w2_stb_b", bus.wb_stb_o, 1);
      chk("w2_adr_b", bus.wb_adr_o, 8'h0B);
      chk("w2_dat_b", bus.wb_dat_o, 8'h11);
      chk("w2_we_b",  bus.wb_we_o, 1);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;
      chk("w2_ready", bus.mem_ready, 1);
      bus.mem_valid = 1'b0;
      tick();

      // 3: full read, bytes 01..04 assembled little-endian
      req(32'h00, 32'h0, 4'b0000);
      tick();
      for (int l = 0; l < 4; l++) begin
         chk($sformatf("r3_stb_l%0d", l), bus.wb_stb_o, 1);
         chk($sformatf("r3_adr_l%0d", l), bus.wb_adr_o, 32'(l));
         chk($sformatf("r3_we_l%0d", l),  bus.wb_we_o, 0);
         bus.wb_dat_i = 8'(l + 1);
         bus.wb_ack_i = 1'b1;
         tick();
         bus.wb_ack_i = 1'b0;
         if (l < 3) begin
            chk($sformatf("r3_gap_stb_%0d", l), bus.wb_stb_o, 0);
            chk($sformatf("r3_gap_rdy_%0d", l), bus.mem_ready, 0);
            tick();
         end
      end
      chk("r3_ready", bus.mem_ready, 1);
      chk("r3_rdata", bus.mem_rdata, 32'h0403_0201);
      chk("r3_err",   bus.o_bus_err, 0);
      bus.mem_valid = 1'b0;
      tick();

      // 4: read with error (and coincident ack) on lane 1
      req(32'h20, 32'h0, 4'b0000);
      tick();
      chk("r4_adr0", bus.wb_adr_o, 8'h20);
      bus.wb_dat_i = 8'hAA;
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;
      tick();
      chk("r4_adr1", bus.wb_adr_o, 8'h21);
      bus.wb_err_i = 1'b1;
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_err_i = 1'b0;
      bus.wb_ack_i = 1'b0;
      chk("r4_ready", bus.mem_ready, 1);
      chk("r4_err",   bus.o_bus_err, 1);
      chk("r4_rdata", bus.mem_rdata, 32'hFFFF_FFFF);
      chk("r4_stb",   bus.wb_stb_o, 0);
      bus.mem_valid = 1'b0;
      tick();
      chk("r4_no_more_cyc", bus.wb_cyc_o, 0);
      chk("r4_err_pulse",   bus.o_bus_err, 0);

      // Wait states: strobe holds until ack
      req(32'h0C, 32'hCAFE_BABE, 4'b0100);
      tick();
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("ws_stb_%0d", c), bus.wb_stb_o, 1);
         chk($sformatf("ws_rdy_%0d", c), bus.mem_ready, 0);
         tick();
      end
      chk("ws_adr", bus.wb_adr_o, 8'h0E);
      chk("ws_dat", bus.wb_dat_o, 8'hFE);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;
      chk("ws_ready", bus.mem_ready, 1);
      bus.mem_valid = 1'b0;
      tick();

      // 5: reset during the GAP of a 4-lane write
      req(32'h40, 32'h5566_7788, 4'b1111);
      tick();
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;
      chk("rs_gap_stb", bus.wb_stb_o, 0);
      rst_n = 1'b0;
      bus.mem_valid = 1'b0;
      tick();
      chk("rs_cyc",   bus.wb_cyc_o, 0);
      chk("rs_stb",   bus.wb_stb_o, 0);
      chk("rs_ready", bus.mem_ready, 0);
      rst_n = 1'b1;
      tick();
      chk("rs_ready_after", bus.mem_ready, 0);
      chk("rs_cyc_after",   bus.wb_cyc_o, 0);
      wd = 32'h5566_7788;
      req(32'h40, wd, 4'b1111);
      tick();
      for (int l = 0; l < 4; l++) begin
         chk($sformatf("rw_adr_l%0d", l), bus.wb_adr_o, 32'h40 + 32'(l));
         chk($sformatf("rw_dat_l%0d", l), bus.wb_dat_o, (wd >> (8 * l)) & 32'hFF);
         bus.wb_ack_i = 1'b1;
         tick();
         bus.wb_ack_i = 1'b0;
         if (l < 3) tick();
      end
      chk("rw_ready", bus.mem_ready, 1);
      chk("rw_err",   bus.o_bus_err, 0);
      bus.mem_valid = 1'b0;
      tick();

`ifdef WB_BRIDGE_TIMEOUT_EN
      // 6: slave never answers; abort after 4 BUS cycles
      req(32'h00, 32'h0, 4'b0000);
      tick();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("to_stb_%0d", c), bus.wb_stb_o, 1);
         chk($sformatf("to_rdy_%0d", c), bus.mem_ready, 0);
         tick();
      end
      chk("to_ready", bus.mem_ready, 1);
      chk("to_err",   bus.o_bus_err, 1);
      chk("to_rdata", bus.mem_rdata, 32'hFFFF_FFFF);
      bus.mem_valid = 1'b0;
      tick();
      chk("to_cyc", bus.wb_cyc_o, 0);
`else
      // Without the timeout feature a silent slave stalls the beat indefinitely
      req(32'h30, 32'h0000_005A, 4'b0001);
      tick();
      ok = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (bus.wb_stb_o !== 1'b1 || bus.mem_ready !== 1'b0) ok = 1'b0;
         tick();
      end
      chk("nt_stall", 32'(ok), 1);
      bus.wb_ack_i = 1'b1;
      tick();
      bus.wb_ack_i = 1'b0;
      chk("nt_ready", bus.mem_ready, 1);
      chk("nt_err",   bus.o_bus_err, 0);
      bus.mem_valid = 1'b0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
